// File: rtl/imem_access_ctrl_if.sv
// Bundle of the fetch, loader and IMEM-side signals around imem_access_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
`ifndef IMEM_ADDR_W
`define IMEM_ADDR_W 5
`endif
`ifndef IMEM_W
`define IMEM_W 32
`endif

interface imem_access_ctrl_if #(
    parameter int ADDR_W = `IMEM_ADDR_W,
    parameter int DATA_W = `IMEM_W
);
    // fetch side
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              core_stall;
    // loader / debug side
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_boot_done;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              err;
    // IMEM port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_boot_done, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, core_stall,
               d_gnt, d_rvalid, d_rdata, err,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_boot_done, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, core_stall,
               d_gnt, d_rvalid, d_rdata, err,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_access_ctrl.sv
// Single-port IMEM arbiter: BOOT phase gives the loader the port, RUN gives fetch
// fixed priority with a starvation guard. Read data is registered (fetch output reg).
`ifndef IMEM_ADDR_W
`define IMEM_ADDR_W 5
`endif
`ifndef IMEM_W
`define IMEM_W 32
`endif

module imem_access_ctrl #(
    parameter int ADDR_W     = `IMEM_ADDR_W,
    parameter int DATA_W     = `IMEM_W,
    parameter int DEPTH      = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_access_ctrl_if.slave  bus
);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    typedef struct packed {
        logic              gnt;
        logic              we;
        logic [ADDR_W-1:0] addr;
    } acc_t;

    localparam logic [3:0]      SMAX    = 4'(STARVE_MAX);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state, state_nxt;
    logic [3:0]        starve;
    logic              f_gnt, d_gnt;
    acc_t              acc;
    logic              in_rng;
    logic [DATA_W-1:0] rd_word;

    logic              f_rvalid_q, d_rvalid_q, err_q;
    logic [DATA_W-1:0] f_rdata_q, d_rdata_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    // next state: RUN is terminal, so boot_done is ignored once there
    always_comb begin
        state_nxt = state;
        if (state == BOOT && bus.d_boot_done) state_nxt = RUN;
    end

    // grant outputs
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        case (state)
            BOOT: d_gnt = bus.d_req;
            RUN: begin
                if (bus.d_req && starve == SMAX) begin
                    d_gnt = 1'b1;
                end else begin
                    f_gnt = bus.f_req;
                    d_gnt = bus.d_req & ~bus.f_req;
                end
            end
            default: ;
        endcase
    end

    // counts loader cycles lost to fetch; any grant or idle loader clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve <= '0;
        else if (state == RUN && bus.d_req && !d_gnt)
            starve <= (starve == SMAX) ? SMAX : starve + 4'd1;
        else
            starve <= '0;
    end

    always_comb begin
        acc.gnt  = f_gnt | d_gnt;
        acc.we   = d_gnt & bus.d_we;
        acc.addr = d_gnt ? bus.d_addr : bus.f_addr;
    end

    assign in_rng  = {1'b0, acc.addr} < DEPTH_L;
    assign rd_word = in_rng ? bus.mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            f_rvalid_q <= f_gnt;
            if (f_gnt) f_rdata_q <= rd_word;
            d_rvalid_q <= d_gnt & ~bus.d_we;
            if (d_gnt && !bus.d_we) d_rdata_q <= rd_word;
            if (acc.gnt && !in_rng) err_q <= 1'b1;
        end
    end

    assign bus.f_gnt      = f_gnt;
    assign bus.d_gnt      = d_gnt;
    assign bus.core_stall = bus.f_req & ~f_gnt;
    assign bus.f_rvalid   = f_rvalid_q;
    assign bus.f_rdata    = f_rdata_q;
    assign bus.d_rvalid   = d_rvalid_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.err        = err_q;
    assign bus.mem_addr   = acc.addr;
    assign bus.mem_we     = acc.we & in_rng;
    assign bus.mem_wdata  = bus.d_wdata;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed bench for imem_access_ctrl with a 32-word IMEM model behind it
// (words 16..31 exist in the model so out-of-range writes would be visible).
`timescale 1ns/1ps

module tb_imem_access_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_init;
    logic [31:0] mem [32];

    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    imem_access_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    imem_access_ctrl #(.ADDR_W(5), .DATA_W(32), .DEPTH(16), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.f_req = 0; bus.f_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.d_boot_done = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        mem_init = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        mem_init = 0;
        total++; if (bus.f_rvalid !== 1'b0) $display("FAIL rst_f_rvalid got %0b exp 0", bus.f_rvalid); else pass_cnt++;
        total++; if (bus.d_rvalid !== 1'b0) $display("FAIL rst_d_rvalid got %0b exp 0", bus.d_rvalid); else pass_cnt++;
        total++; if (bus.f_rdata !== 32'h0) $display("FAIL rst_f_rdata got %h exp 0", bus.f_rdata); else pass_cnt++;
        total++; if (bus.d_rdata !== 32'h0) $display("FAIL rst_d_rdata got %h exp 0", bus.d_rdata); else pass_cnt++;
        total++; if (bus.err !== 1'b0) $display("FAIL rst_err got %0b exp 0", bus.err); else pass_cnt++;
        total++; if ({bus.f_gnt, bus.d_gnt, bus.core_stall, bus.mem_we} !== 4'b0000)
            $display("FAIL rst_comb got %b exp 0000", {bus.f_gnt, bus.d_gnt, bus.core_stall, bus.mem_we}); else pass_cnt++;
        rst_n = 1;
    endtask

    task automatic test_boot_load();
        logic [31:0] w [2];
        w[0] = 32'h00F0_0193;
        w[1] = 32'h0030_0113;
        for (int i = 0; i < 2; i++) begin
            cyc();
            bus.f_req = 1; bus.f_addr = '0;
            bus.d_req = 1; bus.d_we = 1; bus.d_addr = 5'(i); bus.d_wdata = w[i];
            #1;
            total++; if ({bus.f_gnt, bus.core_stall} !== 2'b01) $display("FAIL boot_stall got %b exp 01", {bus.f_gnt, bus.core_stall}); else pass_cnt++;
            total++; if ({bus.d_gnt, bus.mem_we} !== 2'b11) $display("FAIL boot_write got %b exp 11", {bus.d_gnt, bus.mem_we}); else pass_cnt++;
        end
        cyc();
        bus.d_req = 0; bus.d_we = 0; bus.d_boot_done = 1;
        #1;
        total++; if ({bus.f_gnt, bus.core_stall} !== 2'b01) $display("FAIL boot_done_stall got %b exp 01", {bus.f_gnt, bus.core_stall}); else pass_cnt++;
        cyc();
        bus.d_boot_done = 0;
        #1;
        total++; if ({bus.f_gnt, bus.core_stall} !== 2'b10) $display("FAIL run_first_gnt got %b exp 10", {bus.f_gnt, bus.core_stall}); else pass_cnt++;
        cyc();
        bus.f_req = 0;
        #1;
        total++; if (bus.f_rvalid !== 1'b1) $display("FAIL run_first_rvalid got %0b exp 1", bus.f_rvalid); else pass_cnt++;
        total++; if (bus.f_rdata !== 32'h00F0_0193) $display("FAIL run_first_rdata got %h exp 00f00193", bus.f_rdata); else pass_cnt++;
        total++; if (mem[1] !== 32'h0030_0113) $display("FAIL boot_mem1 got %h exp 00300113", mem[1]); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h00F0_0193;
        exp_w[1] = 32'h0030_0113;
        exp_w[2] = 32'hA500_0002;
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.f_req  = (i < 3);
            bus.f_addr = 5'(i);
            #1;
            if (i < 3) begin
                total++; if (bus.f_gnt !== 1'b1) $display("FAIL b2b_gnt%0d got %0b exp 1", i, bus.f_gnt); else pass_cnt++;
            end
            if (i > 0) begin
                total++; if (bus.f_rvalid !== 1'b1) $display("FAIL b2b_rvalid%0d got %0b exp 1", i, bus.f_rvalid); else pass_cnt++;
                total++; if (bus.f_rdata !== exp_w[i-1]) $display("FAIL b2b_rdata%0d got %h exp %h", i, bus.f_rdata, exp_w[i-1]); else pass_cnt++;
            end
        end
        cyc();
        #1;
        total++; if (bus.f_rvalid !== 1'b0) $display("FAIL b2b_rvalid_drop got %0b exp 0", bus.f_rvalid); else pass_cnt++;
        total++; if (bus.f_rdata !== 32'hA500_0002) $display("FAIL b2b_rdata_hold got %h exp a5000002", bus.f_rdata); else pass_cnt++;
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 5; i++) begin
            cyc();
            bus.f_req = 1; bus.f_addr = '0;
            bus.d_req = 1; bus.d_we = 0; bus.d_addr = 5'd1;
            #1;
            if (i < 4) begin
                total++; if ({bus.d_gnt, bus.f_gnt} !== 2'b01) $display("FAIL starve_deny%0d got %b exp 01", i, {bus.d_gnt, bus.f_gnt}); else pass_cnt++;
            end else begin
                total++; if ({bus.d_gnt, bus.f_gnt, bus.core_stall} !== 3'b101)
                    $display("FAIL starve_force got %b exp 101", {bus.d_gnt, bus.f_gnt, bus.core_stall}); else pass_cnt++;
                total++; if (bus.mem_addr !== 5'd1) $display("FAIL starve_addr got %0d exp 1", bus.mem_addr); else pass_cnt++;
            end
        end
        cyc();
        bus.d_req = 0;
        #1;
        total++; if (bus.d_rvalid !== 1'b1) $display("FAIL starve_rvalid got %0b exp 1", bus.d_rvalid); else pass_cnt++;
        total++; if (bus.d_rdata !== 32'h0030_0113) $display("FAIL starve_rdata got %h exp 00300113", bus.d_rdata); else pass_cnt++;
        total++; if (bus.f_rvalid !== 1'b0) $display("FAIL starve_f_rvalid got %0b exp 0", bus.f_rvalid); else pass_cnt++;
        total++; if (dut.starve !== 4'd0) $display("FAIL starve_clear got %0d exp 0", dut.starve); else pass_cnt++;
        total++; if (bus.f_gnt !== 1'b1) $display("FAIL starve_fetch_back got %0b exp 1", bus.f_gnt); else pass_cnt++;
        cyc();
        bus.f_req = 0;
    endtask

    task automatic test_out_of_range();
        cyc();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 5'd20; bus.d_wdata = 32'h1234_5678;
        #1;
        total++; if ({bus.d_gnt, bus.mem_we} !== 2'b10) $display("FAIL oor_wr got %b exp 10", {bus.d_gnt, bus.mem_we}); else pass_cnt++;
        cyc();
        bus.d_req = 0; bus.d_we = 0;
        bus.f_req = 1; bus.f_addr = 5'd20;
        #1;
        total++; if (bus.f_gnt !== 1'b1) $display("FAIL oor_f_gnt got %0b exp 1", bus.f_gnt); else pass_cnt++;
        total++; if (bus.err !== 1'b1) $display("FAIL oor_err_set got %0b exp 1", bus.err); else pass_cnt++;
        total++; if (bus.d_rvalid !== 1'b0) $display("FAIL oor_wr_rvalid got %0b exp 0", bus.d_rvalid); else pass_cnt++;
        cyc();
        bus.f_req = 0;
        #1;
        total++; if (bus.f_rvalid !== 1'b1) $display("FAIL oor_f_rvalid got %0b exp 1", bus.f_rvalid); else pass_cnt++;
        total++; if (bus.f_rdata !== 32'h0) $display("FAIL oor_f_rdata got %h exp 0", bus.f_rdata); else pass_cnt++;
        total++; if (mem[20] !== 32'hA500_0014) $display("FAIL oor_mem_unchanged got %h exp a5000014", mem[20]); else pass_cnt++;
        repeat (3) cyc();
        total++; if (bus.err !== 1'b1) $display("FAIL oor_err_sticky got %0b exp 1", bus.err); else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        cyc();
        bus.f_req = 1; bus.f_addr = 5'd1;
        #1;
        total++; if (bus.f_gnt !== 1'b1) $display("FAIL mid_gnt got %0b exp 1", bus.f_gnt); else pass_cnt++;
        cyc();
        total++; if (bus.f_rvalid !== 1'b1) $display("FAIL mid_pre_rvalid got %0b exp 1", bus.f_rvalid); else pass_cnt++;
        rst_n = 0;
        #1;
        total++; if (bus.f_rvalid !== 1'b0) $display("FAIL mid_rvalid got %0b exp 0", bus.f_rvalid); else pass_cnt++;
        total++; if (bus.f_rdata !== 32'h0) $display("FAIL mid_rdata got %h exp 0", bus.f_rdata); else pass_cnt++;
        total++; if (bus.err !== 1'b0) $display("FAIL mid_err got %0b exp 0", bus.err); else pass_cnt++;
        total++; if ({bus.f_gnt, bus.core_stall} !== 2'b01) $display("FAIL mid_boot got %b exp 01", {bus.f_gnt, bus.core_stall}); else pass_cnt++;
        cyc();
        rst_n = 1;
        total++; if ({mem[0], mem[1]} !== {32'h00F0_0193, 32'h0030_0113})
            $display("FAIL mid_mem_kept got %h %h exp 00f00193 00300113", mem[0], mem[1]); else pass_cnt++;
    endtask

    task automatic test_same_cycle_boot_done();
        cyc();
        bus.f_req = 1; bus.f_addr = 5'd2;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 5'd2; bus.d_wdata = 32'hCAFE_0113;
        bus.d_boot_done = 1;
        #1;
        total++; if ({bus.d_gnt, bus.f_gnt, bus.mem_we, bus.core_stall} !== 4'b1011)
            $display("FAIL sc_wr got %b exp 1011", {bus.d_gnt, bus.f_gnt, bus.mem_we, bus.core_stall}); else pass_cnt++;
        cyc();
        bus.d_req = 0; bus.d_we = 0; bus.d_boot_done = 0;
        #1;
        total++; if (bus.f_gnt !== 1'b1) $display("FAIL sc_run_gnt got %0b exp 1", bus.f_gnt); else pass_cnt++;
        cyc();
        bus.f_addr = 5'd0;
        bus.d_boot_done = 1;
        #1;
        total++; if (bus.f_rvalid !== 1'b1) $display("FAIL sc_rvalid got %0b exp 1", bus.f_rvalid); else pass_cnt++;
        total++; if (bus.f_rdata !== 32'hCAFE_0113) $display("FAIL sc_rdata got %h exp cafe0113", bus.f_rdata); else pass_cnt++;
        cyc();
        bus.d_boot_done = 0;
        bus.f_addr = 5'd1;
        #1;
        total++; if (bus.f_rdata !== 32'h00F0_0193) $display("FAIL sc_word0 got %h exp 00f00193", bus.f_rdata); else pass_cnt++;
        total++; if (bus.f_gnt !== 1'b1) $display("FAIL sc_done_in_run got %0b exp 1", bus.f_gnt); else pass_cnt++;
        cyc();
        bus.f_req = 0;
        #1;
        total++; if (bus.f_rdata !== 32'h0030_0113) $display("FAIL sc_word1 got %h exp 00300113", bus.f_rdata); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_boot_load();
        test_back_to_back();
        test_starvation();
        test_out_of_range();
        test_reset_mid_read();
        test_same_cycle_boot_done();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
